// File: rtl/accel_pair_sequencer.sv
// accel_pair_sequencer: issues every ordered body pair (i, j), i != j, into
// the getAccl pipeline at one pair per clock. A tag line of LATENCY+1 stages
// runs alongside getAccl so each ax/ay result is labelled with its target body
// and the per-body / per-run last flags.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, num_bodies        run request and body count N (sampled on accept)
//   busy, done               run in progress, one-cycle end-of-run pulse
//   rd_addr_a, rd_addr_b     body RAM addresses for body i and body j
//   rd_xa/ya, rd_xb/yb/mb    body RAM data, sampled at the end of the address cycle
//   x1, y1, x2, y2, m2       registered getAccl operands
//   ax, ay                   getAccl results, LATENCY cycles after operands
//   res_valid, res_idx       result beat valid and target body i
//   res_ax, res_ay           registered getAccl results
//   res_last_i, res_last     last beat for body i, last beat of the run
module accel_pair_sequencer #(
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned LATENCY = 122
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   num_bodies,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] rd_addr_a,
  output logic [IDX_W-1:0] rd_addr_b,
  input  logic [63:0]      rd_xa,
  input  logic [63:0]      rd_ya,
  input  logic [63:0]      rd_xb,
  input  logic [63:0]      rd_yb,
  input  logic [63:0]      rd_mb,
  output logic [63:0]      x1,
  output logic [63:0]      y1,
  output logic [63:0]      x2,
  output logic [63:0]      y2,
  output logic [63:0]      m2,
  input  logic [63:0]      ax,
  input  logic [63:0]      ay,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_idx,
  output logic [63:0]      res_ax,
  output logic [63:0]      res_ay,
  output logic             res_last_i,
  output logic             res_last
);

  localparam int unsigned TAG_DEPTH = LATENCY + 1;
  // Tag layout: {valid, last, last_i, idx}
  localparam int unsigned TAG_W     = IDX_W + 3;
  localparam int unsigned TAG_VLD   = TAG_W - 1;
  localparam int unsigned TAG_LAST  = TAG_W - 2;
  localparam int unsigned TAG_LASTI = TAG_W - 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W:0]   n_q, n_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [63:0]      x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d, m2_q, m2_d;
  logic [TAG_W-1:0] tag_q [TAG_DEPTH];
  logic [TAG_W-1:0] tag_d [TAG_DEPTH];
  logic             res_valid_q, res_valid_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic [63:0]      res_ax_q, res_ax_d, res_ay_q, res_ay_d;
  logic             res_last_i_q, res_last_i_d;
  logic             res_last_q, res_last_d;

  logic [IDX_W-1:0] last_idx, last_j, j_inc, j_step;
  logic             last_i_c, last_c, issue;
  logic [TAG_W-1:0] tag_out;

  // Pair walk: end-of-row detection and j advance that hops over j == i.
  always_comb begin
    last_idx = IDX_W'(n_q - 1'b1);
    last_j   = (i_q == last_idx) ? IDX_W'(last_idx - 1'b1) : last_idx;
    last_i_c = (j_q == last_j);
    last_c   = last_i_c && (i_q == last_idx);
    j_inc    = IDX_W'(j_q + 1'b1);
    // j_inc cannot wrap here: a wrap only happens on the row's final j.
    j_step   = (j_inc == i_q) ? IDX_W'(j_q + IDX_W'(2)) : j_inc;
  end

  // Next-state and control outputs.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = num_bodies;
          i_d     = '0;
          j_d     = IDX_W'(1);
          state_d = (num_bodies >= (IDX_W+1)'(2)) ? S_ISSUE : S_FIN;
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (last_c) begin
          state_d = S_DRAIN;
        end else if (last_i_c) begin
          // New row i+1 >= 1, so its first partner is always body 0.
          i_d = IDX_W'(i_q + 1'b1);
          j_d = '0;
        end else begin
          j_d = j_step;
        end
      end
      S_DRAIN: begin
        if (res_valid_q && res_last_q) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_FIN);
  end

  // Operand capture (held outside issue cycles) and tag line shift.
  always_comb begin
    x1_d = issue ? rd_xa : x1_q;
    y1_d = issue ? rd_ya : y1_q;
    x2_d = issue ? rd_xb : x2_q;
    y2_d = issue ? rd_yb : y2_q;
    m2_d = issue ? rd_mb : m2_q;
    tag_d[0] = issue ? {1'b1, last_c, last_i_c, i_q} : '0;
    for (int k = 1; k < TAG_DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  // Result stage: the last tag stage lines up with ax/ay.
  always_comb begin
    tag_out      = tag_q[TAG_DEPTH-1];
    res_valid_d  = tag_out[TAG_VLD];
    res_idx_d    = tag_out[TAG_VLD] ? tag_out[IDX_W-1:0] : res_idx_q;
    res_ax_d     = tag_out[TAG_VLD] ? ax : res_ax_q;
    res_ay_d     = tag_out[TAG_VLD] ? ay : res_ay_q;
    res_last_i_d = tag_out[TAG_VLD] & tag_out[TAG_LASTI];
    res_last_d   = tag_out[TAG_VLD] & tag_out[TAG_LAST];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      i_q          <= '0;
      j_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      x1_q         <= 64'h0;
      y1_q         <= 64'h0;
      x2_q         <= 64'h0;
      y2_q         <= 64'h0;
      m2_q         <= 64'h0;
      for (int k = 0; k < TAG_DEPTH; k++) tag_q[k] <= '0;
      res_valid_q  <= 1'b0;
      res_idx_q    <= '0;
      res_ax_q     <= 64'h0;
      res_ay_q     <= 64'h0;
      res_last_i_q <= 1'b0;
      res_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      i_q          <= i_d;
      j_q          <= j_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      x2_q         <= x2_d;
      y2_q         <= y2_d;
      m2_q         <= m2_d;
      for (int k = 0; k < TAG_DEPTH; k++) tag_q[k] <= tag_d[k];
      res_valid_q  <= res_valid_d;
      res_idx_q    <= res_idx_d;
      res_ax_q     <= res_ax_d;
      res_ay_q     <= res_ay_d;
      res_last_i_q <= res_last_i_d;
      res_last_q   <= res_last_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_addr_a  = i_q;
  assign rd_addr_b  = j_q;
  assign x1         = x1_q;
  assign y1         = y1_q;
  assign x2         = x2_q;
  assign y2         = y2_q;
  assign m2         = m2_q;
  assign res_valid  = res_valid_q;
  assign res_idx    = res_idx_q;
  assign res_ax     = res_ax_q;
  assign res_ay     = res_ay_q;
  assign res_last_i = res_last_i_q;
  assign res_last   = res_last_q;

endmodule

// File: tb/tb_accel_pair_sequencer.sv
// Bench for accel_pair_sequencer: body RAM model, a LATENCY-deep getAccl
// model, a beat monitor, and directed runs checked against a pair-order model.
module tb_accel_pair_sequencer;

  localparam int unsigned IDX_W   = 8;
  localparam int unsigned LATENCY = 122;
  localparam int unsigned NMEM    = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [IDX_W:0]   num_bodies;
  logic             busy, done;
  logic [IDX_W-1:0] rd_addr_a, rd_addr_b;
  logic [63:0]      rd_xa, rd_ya, rd_xb, rd_yb, rd_mb;
  logic [63:0]      x1, y1, x2, y2, m2, ax, ay;
  logic             res_valid, res_last_i, res_last;
  logic [IDX_W-1:0] res_idx;
  logic [63:0]      res_ax, res_ay;

  always #5 clk = ~clk;

  accel_pair_sequencer #(.IDX_W(IDX_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .start(start), .num_bodies(num_bodies),
    .busy(busy), .done(done), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_xa(rd_xa), .rd_ya(rd_ya), .rd_xb(rd_xb), .rd_yb(rd_yb), .rd_mb(rd_mb),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .m2(m2), .ax(ax), .ay(ay),
    .res_valid(res_valid), .res_idx(res_idx), .res_ax(res_ax), .res_ay(res_ay),
    .res_last_i(res_last_i), .res_last(res_last)
  );

  // Body RAM: data presented for the address of the current cycle.
  logic [63:0] mem_x [NMEM];
  logic [63:0] mem_y [NMEM];
  logic [63:0] mem_m [NMEM];
  assign rd_xa = mem_x[rd_addr_a];
  assign rd_ya = mem_y[rd_addr_a];
  assign rd_xb = mem_x[rd_addr_b];
  assign rd_yb = mem_y[rd_addr_b];
  assign rd_mb = mem_m[rd_addr_b];

  // Golden getAccl: a = m2 * d / |d|^3, d = p2 - p1.
  function automatic logic [127:0] accel(input logic [63:0] xa, ya, xb, yb, mb);
    real dx, dy, r2, s;
    dx = $bitstoreal(xb) - $bitstoreal(xa);
    dy = $bitstoreal(yb) - $bitstoreal(ya);
    r2 = dx * dx + dy * dy;
    if (r2 == 0.0) return 128'h0;
    s = $bitstoreal(mb) / (r2 * $sqrt(r2));
    return {$realtobits(dx * s), $realtobits(dy * s)};
  endfunction

  function automatic logic [127:0] exp_acc(input int i, input int j);
    return accel(mem_x[i], mem_y[i], mem_x[j], mem_y[j], mem_m[j]);
  endfunction

  logic [127:0] gpipe [LATENCY];
  always @(posedge clk) begin
    gpipe[0] <= accel(x1, y1, x2, y2, m2);
    for (int k = 1; k < LATENCY; k++) gpipe[k] <= gpipe[k-1];
  end
  assign ax = gpipe[LATENCY-1][127:64];
  assign ay = gpipe[LATENCY-1][63:0];

  // Beat / done monitor.
  typedef struct {
    int          cyc;
    int          idx;
    bit          last_i;
    bit          last;
    logic [63:0] ax;
    logic [63:0] ay;
  } beat_t;

  beat_t beats[$];
  int    cyc = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    busy_after_done = 2;
  bit    done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (res_valid) beats.push_back('{cyc, int'(res_idx), res_last_i, res_last, res_ax, res_ay});
    if (done_prev) busy_after_done = int'(busy);
    done_prev = done;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, k, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_body(input int k, input real x, input real y, input real m);
    mem_x[k] = $realtobits(x);
    mem_y[k] = $realtobits(y);
    mem_m[k] = $realtobits(m);
  endtask

  task automatic init_bodies();
    for (int k = 0; k < NMEM; k++)
      set_body(k, 3.0 * k + 1.0, (k % 7) * 5.0 - 2.0, 100.0 + k);
  endtask

  task automatic start_run(input int n, output int t0);
    tick();
    beats.delete();
    done_cnt = 0;
    busy_after_done = 2;
    start = 1'b1;
    num_bodies = (IDX_W+1)'(n);
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string name, input int budget);
    int waited;
    waited = 0;
    while (done_cnt == 0 && waited < budget) begin
      tick();
      waited++;
    end
    check({name, " done_timeout"}, 0, 64'(done_cnt > 0), 64'd1);
  endtask

  task automatic settle();
    repeat (LATENCY + 10) tick();
  endtask

  // Compare collected beats against i-major, j-ascending pair order.
  task automatic verify_run(input string name, input int n, input int t0);
    int           k, lj, nb;
    logic [127:0] e;
    nb = (n >= 2) ? n * (n - 1) : 0;
    k  = 0;
    check({name, " beats"}, 0, 64'(beats.size()), 64'(nb));
    check({name, " done_cnt"}, 0, 64'(done_cnt), 64'd1);
    for (int i = 0; i < n; i++) begin
      lj = (i == n - 1) ? n - 2 : n - 1;
      for (int j = 0; j < n; j++) begin
        if (i != j && k < beats.size()) begin
          e = exp_acc(i, j);
          check({name, " lat"}, k, 64'(beats[k].cyc - t0), 64'(LATENCY + 2 + k));
          check({name, " idx"}, k, 64'(beats[k].idx), 64'(i));
          check({name, " last_i"}, k, 64'(beats[k].last_i), 64'(j == lj));
          check({name, " last"}, k, 64'(beats[k].last), 64'(j == lj && i == n - 1));
          check({name, " ax"}, k, beats[k].ax, e[127:64]);
          check({name, " ay"}, k, beats[k].ay, e[63:0]);
          k++;
        end
      end
    end
    if (n < 2)
      check({name, " done_lat"}, 0, 64'((done_cyc - t0) <= 2), 64'd1);
    else if (beats.size() > 0)
      check({name, " done_after_last"}, 0, 64'(done_cyc > beats[beats.size()-1].cyc), 64'd1);
  endtask

  task automatic run_case(input string name, input int n);
    int t0;
    start_run(n, t0);
    wait_done(name, n * (n - 1) + LATENCY + 20);
    settle();
    verify_run(name, n, t0);
  endtask

  typedef struct { int n; } run_vec_t;
  typedef struct { int idx; int j; bit last_i; } pair_vec_t;

  run_vec_t  runs [6];
  pair_vec_t tbl4 [12];
  int        prof_a [$];

  initial begin
    int t0, t0b;
    runs = '{'{0}, '{1}, '{3}, '{4}, '{5}, '{256}};
    tbl4 = '{'{0, 1, 1'b0}, '{0, 2, 1'b0}, '{0, 3, 1'b1},
             '{1, 0, 1'b0}, '{1, 2, 1'b0}, '{1, 3, 1'b1},
             '{2, 0, 1'b0}, '{2, 1, 1'b0}, '{2, 3, 1'b1},
             '{3, 0, 1'b0}, '{3, 1, 1'b0}, '{3, 2, 1'b1}};

    rst = 1'b1;
    start = 1'b0;
    num_bodies = '0;
    init_bodies();
    repeat (3) tick();

    // Reset state.
    check("rst busy", 0, 64'(busy), 64'd0);
    check("rst done", 0, 64'(done), 64'd0);
    check("rst res_valid", 0, 64'(res_valid), 64'd0);
    check("rst res_last", 0, 64'({res_last_i, res_last}), 64'd0);
    check("rst rd_addr", 0, 64'({rd_addr_a, rd_addr_b}), 64'd0);
    check("rst res_idx", 0, 64'(res_idx), 64'd0);
    check("rst x1", 0, x1, 64'h0);
    check("rst m2", 0, m2, 64'h0);
    check("rst res_ax", 0, res_ax, 64'h0);
    check("rst res_ay", 0, res_ay, 64'h0);
    rst = 1'b0;
    tick();

    // N = 2 timing and values with the two named bodies.
    set_body(0, 10.0, 20.0, 500.0);
    set_body(1, 0.0, 0.0, 500.0);
    start_run(2, t0);
    check("n2 busy_running", 0, 64'(busy), 64'd1);
    wait_done("n2", 200);
    settle();
    verify_run("n2", 2, t0);
    check("n2 busy_after_done", 0, 64'(busy_after_done), 64'd0);
    init_bodies();

    // Table of run sizes, including degenerate and full-range N.
    foreach (runs[r]) run_case($sformatf("n%0d", runs[r].n), runs[r].n);

    // N = 4 literal pair table.
    start_run(4, t0);
    wait_done("tbl4", 200);
    settle();
    check("tbl4 beats", 0, 64'(beats.size()), 64'd12);
    for (int k = 0; k < 12; k++) begin
      if (k < beats.size()) begin
        check("tbl4 idx", k, 64'(beats[k].idx), 64'(tbl4[k].idx));
        check("tbl4 last_i", k, 64'(beats[k].last_i), 64'(tbl4[k].last_i));
        check("tbl4 j_ax", k, beats[k].ax, exp_acc(tbl4[k].idx, tbl4[k].j) >> 64);
        check("tbl4 gap", k, 64'(beats[k].cyc - t0), 64'(LATENCY + 2 + k));
      end
    end

    // Start re-pulsed mid-run with a different N: ignored.
    start_run(3, t0);
    repeat (3) tick();
    start = 1'b1;
    num_bodies = (IDX_W+1)'(5);
    tick();
    start = 1'b0;
    wait_done("ign", 200);
    settle();
    settle();
    verify_run("ign", 3, t0);

    // Reset mid-run: nothing further, then a clean N = 2 run.
    start_run(8, t0);
    repeat (50) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (300) tick();
    check("rst_mid beats", 0, 64'(beats.size()), 64'd0);
    check("rst_mid done", 0, 64'(done_cnt), 64'd0);
    check("rst_mid busy", 0, 64'(busy), 64'd0);
    run_case("post_rst", 2);

    // Back-to-back runs: second start in the cycle after done.
    start_run(3, t0);
    wait_done("b2b_a", 200);
    verify_run("b2b_a", 3, t0);
    prof_a.delete();
    foreach (beats[k]) prof_a.push_back(beats[k].cyc - t0);
    start_run(3, t0b);
    wait_done("b2b_b", 200);
    settle();
    verify_run("b2b_b", 3, t0b);
    check("b2b prof_len", 0, 64'(prof_a.size()), 64'(beats.size()));
    for (int k = 0; k < prof_a.size(); k++)
      if (k < beats.size())
        check("b2b profile", k, 64'(beats[k].cyc - t0b), 64'(prof_a[k]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
